// File: rtl/alu_arbiter_pkg.sv
// Shared opcode/width defines (define.vh set) and arbiter types.
// ALU_ARB_OPCHECK_EN enables the response-side opcode legality flag.
`ifndef ALU_ARB_DEFINE_VH
`define ALU_ARB_DEFINE_VH
`define ALU_OP_W        4
`define ALU_ARB_MAX_REQ 8
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_AND  4'h2
`define ALU_OR   4'h3
`define ALU_XOR  4'h4
`define ALU_ADDI 4'h5
`define ALU_SLLI 4'h6
`define ALU_SRLI 4'h7
`define ALU_SRAI 4'h8
`endif

package alu_arbiter_pkg;
    localparam int unsigned OP_W    = `ALU_OP_W;
    localparam int unsigned MAX_REQ = `ALU_ARB_MAX_REQ;

    localparam logic [OP_W-1:0] OP_ADD  = `ALU_ADD;
    localparam logic [OP_W-1:0] OP_SUB  = `ALU_SUB;
    localparam logic [OP_W-1:0] OP_AND  = `ALU_AND;
    localparam logic [OP_W-1:0] OP_OR   = `ALU_OR;
    localparam logic [OP_W-1:0] OP_XOR  = `ALU_XOR;
    localparam logic [OP_W-1:0] OP_ADDI = `ALU_ADDI;
    localparam logic [OP_W-1:0] OP_SLLI = `ALU_SLLI;
    localparam logic [OP_W-1:0] OP_SRLI = `ALU_SRLI;
    localparam logic [OP_W-1:0] OP_SRAI = `ALU_SRAI;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic op_is_known(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_SLLI, OP_SRLI, OP_SRAI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction
`endif
endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any
);
    int unsigned w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(i_ptr) + k) % 32'(NUM_REQ);
            if (!o_any && i_req[ID_W'(w_idx)]) begin
                o_any                = 1'b1;
                o_grant[ID_W'(w_idx)] = 1'b1;
                o_grant_idx          = ID_W'(w_idx);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU with a one-entry tagged response buffer.
// Define ALU_ARB_OPCHECK_EN to add rsp_err for unrecognised opcodes.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_rs1,
    input  logic [NUM_REQ*32-1:0]   req_rs2,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [31:0]             alu_rs1,
    output logic [31:0]             alu_rs2,
    output logic [OP_W-1:0]         alu_op,
    input  logic [31:0]             alu_output,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data
`ifdef ALU_ARB_OPCHECK_EN
    ,
    output logic                    rsp_err
`endif
);
    if (NUM_REQ < 2 || NUM_REQ > int'(MAX_REQ)) begin : g_bad_num_req
        $error("alu_arbiter: NUM_REQ out of range");
    end

    buf_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [31:0]         r_data;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_gidx;
    logic [ID_W-1:0]     w_ptr_next;
    logic                w_any;
    logic                w_can_issue;
    logic                w_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    assign w_can_issue = (r_state == BUF_EMPTY) || rsp_ready;
    assign w_fire      = w_any && w_can_issue && !rst;
    assign req_ready   = w_grant & {NUM_REQ{w_can_issue && !rst}};
    assign w_ptr_next  = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);

    // One-hot AND-OR mux: no grant means all-zero ALU inputs.
    always_comb begin
        alu_rs1 = '0;
        alu_rs2 = '0;
        alu_op  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            alu_rs1 = alu_rs1 | (req_rs1[i*32 +: 32]     & {32{w_grant[i]}});
            alu_rs2 = alu_rs2 | (req_rs2[i*32 +: 32]     & {32{w_grant[i]}});
            alu_op  = alu_op  | (req_op[i*OP_W +: OP_W] & {OP_W{w_grant[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else if (w_fire) begin
            r_state <= BUF_FULL;
            r_ptr   <= w_ptr_next;
            r_id    <= w_gidx;
            r_data  <= alu_output;
        end else if (r_state == BUF_FULL && rsp_ready) begin
            r_state <= BUF_EMPTY;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_fire) begin
            r_err <= !op_is_known(alu_op);
        end
    end

    assign rsp_err = r_err;
`endif

    assign rsp_valid = (r_state == BUF_FULL);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 3-requester instance share one clock/reset.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [1:0]        v2, rdy2;
    logic [63:0]       rs1_2, rs2_2;
    logic [2*OP_W-1:0] op2;
    logic [31:0]       a1_2, a2_2, out2, rd2;
    logic [OP_W-1:0]   aop2;
    logic              rv2, rr2;
    logic [0:0]        rid2;

    logic [2:0]        v3, rdy3;
    logic [95:0]       rs1_3, rs2_3;
    logic [3*OP_W-1:0] op3;
    logic [31:0]       a1_3, a2_3, out3, rd3;
    logic [OP_W-1:0]   aop3;
    logic              rv3, rr3;
    logic [1:0]        rid3;
`ifdef ALU_ARB_OPCHECK_EN
    logic              err2, err3;
`endif

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDI: return a + b;
            OP_SUB:          return a - b;
            OP_AND:          return a & b;
            OP_OR:           return a | b;
            OP_XOR:          return a ^ b;
            OP_SLLI:         return a << b[4:0];
            OP_SRLI:         return a >> b[4:0];
            OP_SRAI:         return $unsigned($signed(a) >>> b[4:0]);
            default:         return 32'h0;
        endcase
    endfunction

    assign out2 = alu_model(a1_2, a2_2, aop2);
    assign out3 = alu_model(a1_3, a2_3, aop3);

    alu_arbiter #(.NUM_REQ(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_rs1(rs1_2), .req_rs2(rs2_2), .req_op(op2),
        .alu_rs1(a1_2), .alu_rs2(a2_2), .alu_op(aop2), .alu_output(out2),
        .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(rid2), .rsp_data(rd2)
`ifdef ALU_ARB_OPCHECK_EN
        , .rsp_err(err2)
`endif
    );

    alu_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
        .req_rs1(rs1_3), .req_rs2(rs2_3), .req_op(op3),
        .alu_rs1(a1_3), .alu_rs2(a2_3), .alu_op(aop3), .alu_output(out3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(rid3), .rsp_data(rd3)
`ifdef ALU_ARB_OPCHECK_EN
        , .rsp_err(err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v2 = 2'b11; v3 = 3'b111; rr2 = 1'b1; rr3 = 1'b1;
        rs1_2 = '0; rs2_2 = '0; op2 = '0;
        rs1_3 = '0; rs2_3 = '0; op3 = '0;
        tick(); tick();
        n_vec++; if (rdy2 !== 2'b00) begin n_err++; $display("FAIL rst_ready2: got %b want 00", rdy2); end
        n_vec++; if (rdy3 !== 3'b000) begin n_err++; $display("FAIL rst_ready3: got %b want 000", rdy3); end
        n_vec++; if (rv2 !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", rv2); end
        n_vec++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", rd2); end
        n_vec++; if (rid2 !== 1'b0) begin n_err++; $display("FAIL rst_id: got %h want 0", rid2); end
        v2 = '0; v3 = '0; rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (rv2 !== 1'b0 || rv3 !== 1'b0) begin n_err++; $display("FAIL idle_valid[%0d]: got %b%b want 00", i, rv2, rv3); end
            n_vec++; if (rdy2 !== 2'b00 || rdy3 !== 3'b000) begin n_err++; $display("FAIL idle_ready[%0d]: got %b/%b want 0", i, rdy2, rdy3); end
            n_vec++; if (a1_2 !== 32'h0 || a2_2 !== 32'h0 || aop2 !== '0) begin n_err++; $display("FAIL idle_alu[%0d]: got %h %h %h want 0", i, a1_2, a2_2, aop2); end
        end
        v3 = 3'b111; v2 = 2'b11;
        #1;
        n_vec++; if (rdy3 !== 3'b001) begin n_err++; $display("FAIL ptr0_dut3: got %b want 001", rdy3); end
        n_vec++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL ptr0_dut2: got %b want 01", rdy2); end
        v3 = '0; v2 = '0;
    endtask

    task automatic test_single_op();
        rs1_2[31:0] = 32'd5; rs2_2[31:0] = 32'd3; op2[OP_W-1:0] = OP_SUB;
        v2 = 2'b01; rr2 = 1'b1;
        #1;
        n_vec++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", rdy2); end
        n_vec++; if (a1_2 !== 32'd5 || a2_2 !== 32'd3 || aop2 !== OP_SUB) begin n_err++; $display("FAIL single_alu_in: got %h %h %h want 5 3 %h", a1_2, a2_2, aop2, OP_SUB); end
        tick();
        v2 = 2'b00;
        n_vec++; if (rv2 !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rv2); end
        n_vec++; if (rd2 !== 32'd2) begin n_err++; $display("FAIL single_data: got %h want 2", rd2); end
        n_vec++; if (rid2 !== 1'b0) begin n_err++; $display("FAIL single_id: got %h want 0", rid2); end
        tick();
        n_vec++; if (rv2 !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", rv2); end
    endtask

    task automatic test_fairness();
        logic [0:0]  exp_id;
        logic [31:0] exp_data;
        logic [1:0]  exp_rdy;
        do_reset();
        rs1_2 = {32'd10, 32'd1}; rs2_2 = {32'd10, 32'd1}; op2 = {OP_ADD, OP_ADD};
        v2 = 2'b11; rr2 = 1'b1;
        #1;
        n_vec++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL fair_first_ready: got %b want 01", rdy2); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_id   = (i % 2 == 0) ? 1'b0 : 1'b1;
            exp_data = (i % 2 == 0) ? 32'd2 : 32'd20;
            exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
            if (i == 3) v2 = 2'b00;
            n_vec++; if (rv2 !== 1'b1 || rid2 !== exp_id || rd2 !== exp_data) begin n_err++; $display("FAIL fair_rsp[%0d]: got v=%b id=%h d=%h want v=1 id=%h d=%h", i, rv2, rid2, rd2, exp_id, exp_data); end
            if (i < 3) begin
                n_vec++; if (rdy2 !== exp_rdy) begin n_err++; $display("FAIL fair_ready[%0d]: got %b want %b", i, rdy2, exp_rdy); end
            end
        end
        tick();
        n_vec++; if (rv2 !== 1'b0) begin n_err++; $display("FAIL fair_drain: got %b want 0", rv2); end
    endtask

    task automatic test_backpressure();
        rs1_2[31:0] = 32'h8000_0000; rs2_2[31:0] = 32'd31; op2[OP_W-1:0] = OP_SRAI;
        v2 = 2'b01; rr2 = 1'b1;
        #1;
        n_vec++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL bp_first_ready: got %b want 01", rdy2); end
        tick();
        rs1_2[63:32] = 32'd7; rs2_2[63:32] = 32'd8; op2[2*OP_W-1:OP_W] = OP_ADD;
        v2 = 2'b10; rr2 = 1'b0;
        n_vec++; if (rv2 !== 1'b1 || rd2 !== 32'hFFFF_FFFF || rid2 !== 1'b0) begin n_err++; $display("FAIL bp_full: got v=%b d=%h id=%h want 1 ffffffff 0", rv2, rd2, rid2); end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (rdy2 !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 00", i, rdy2); end
            n_vec++; if (a1_2 !== 32'd7 || aop2 !== OP_ADD) begin n_err++; $display("FAIL bp_alu_in[%0d]: got %h %h want 7 %h", i, a1_2, aop2, OP_ADD); end
            tick();
            n_vec++; if (rv2 !== 1'b1 || rd2 !== 32'hFFFF_FFFF || rid2 !== 1'b0) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%h want 1 ffffffff 0", i, rv2, rd2, rid2); end
        end
        rr2 = 1'b1;
        #1;
        n_vec++; if (rdy2 !== 2'b10) begin n_err++; $display("FAIL bp_release_ready: got %b want 10", rdy2); end
        tick();
        v2 = 2'b00;
        n_vec++; if (rv2 !== 1'b1 || rd2 !== 32'd15 || rid2 !== 1'b1) begin n_err++; $display("FAIL bp_refill: got v=%b d=%h id=%h want 1 0000000f 1", rv2, rd2, rid2); end
        tick();
        n_vec++; if (rv2 !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", rv2); end
    endtask

    task automatic test_wrap();
        rr3 = 1'b1;
        rs1_3 = {32'd100, 32'd1, 32'd4}; rs2_3 = {32'd1, 32'd2, 32'd4}; op3 = {OP_ADD, OP_ADD, OP_ADD};
        v3 = 3'b010;
        #1;
        n_vec++; if (rdy3 !== 3'b010) begin n_err++; $display("FAIL wrap_r1_ready: got %b want 010", rdy3); end
        tick();
        n_vec++; if (rv3 !== 1'b1 || rid3 !== 2'd1 || rd3 !== 32'd3) begin n_err++; $display("FAIL wrap_r1_rsp: got v=%b id=%h d=%h want 1 1 3", rv3, rid3, rd3); end
        v3 = 3'b001;
        #1;
        n_vec++; if (rdy3 !== 3'b001) begin n_err++; $display("FAIL wrap_r0_ready: got %b want 001", rdy3); end
        tick();
        n_vec++; if (rv3 !== 1'b1 || rid3 !== 2'd0 || rd3 !== 32'd8) begin n_err++; $display("FAIL wrap_r0_rsp: got v=%b id=%h d=%h want 1 0 8", rv3, rid3, rd3); end
        v3 = 3'b101;
        #1;
        n_vec++; if (rdy3 !== 3'b100) begin n_err++; $display("FAIL wrap_ptr1_ready: got %b want 100", rdy3); end
        tick();
        v3 = 3'b000;
        n_vec++; if (rv3 !== 1'b1 || rid3 !== 2'd2 || rd3 !== 32'd101) begin n_err++; $display("FAIL wrap_r2_rsp: got v=%b id=%h d=%h want 1 2 65", rv3, rid3, rd3); end
        tick();
        n_vec++; if (rv3 !== 1'b0) begin n_err++; $display("FAIL wrap_drain: got %b want 0", rv3); end
    endtask

    task automatic test_reset_midop();
        rr2 = 1'b0;
        rs1_2[31:0] = 32'd1; rs2_2[31:0] = 32'd1; op2[OP_W-1:0] = OP_ADD;
        v2 = 2'b01;
        tick();
        v2 = 2'b00;
        n_vec++; if (rv2 !== 1'b1 || rd2 !== 32'd2) begin n_err++; $display("FAIL midrst_full: got v=%b d=%h want 1 2", rv2, rd2); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (rv2 !== 1'b0 || rd2 !== 32'h0) begin n_err++; $display("FAIL midrst_async: got v=%b d=%h want 0 0", rv2, rd2); end
        v2 = 2'b01; rr2 = 1'b1;
        #1;
        n_vec++; if (rdy2 !== 2'b00) begin n_err++; $display("FAIL midrst_ready: got %b want 00", rdy2); end
        tick();
        v2 = 2'b00; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (rv2 !== 1'b0) begin n_err++; $display("FAIL midrst_norsp[%0d]: got %b want 0", i, rv2); end
        end
    endtask

`ifdef ALU_ARB_OPCHECK_EN
    task automatic test_opcheck();
        rr2 = 1'b1;
        rs1_2[31:0] = 32'd9; rs2_2[31:0] = 32'd4; op2[OP_W-1:0] = 4'hF;
        v2 = 2'b01;
        tick();
        op2[OP_W-1:0] = OP_SUB;
        n_vec++; if (rv2 !== 1'b1 || err2 !== 1'b1 || rd2 !== 32'h0) begin n_err++; $display("FAIL opchk_bad: got v=%b err=%b d=%h want 1 1 0", rv2, err2, rd2); end
        tick();
        v2 = 2'b00;
        n_vec++; if (err2 !== 1'b0 || rd2 !== 32'd5) begin n_err++; $display("FAIL opchk_good: got err=%b d=%h want 0 5", err2, rd2); end
        tick();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_midop();
`ifdef ALU_ARB_OPCHECK_EN
        test_opcheck();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
